// File: rtl/regfile_pkg.sv
// regfile_pkg: shared dump FSM encoding and default parameters for regfile_param.
package regfile_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} dump_state_e;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;
endpackage

// File: rtl/regfile_dbg_dump.sv
// regfile_dbg_dump: handshaked sequencer that snapshots and streams every register.
module regfile_dbg_dump
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              dbg_start,
  input  logic              dbg_ready,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_busy,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);
  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end
  // The read port always looks one register ahead so the next beat is captured on accept.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rd_addr = state_q == SEND ? idx_q + 1'b1 : '0;
    if (state_q == IDLE && dbg_start) begin
      state_d = SEND;
      idx_d   = '0;
      data_d  = rd_data;
    end else if (state_q == SEND && dbg_ready) begin
      if (&idx_q) state_d = DONE;
      else begin
        idx_d  = idx_q + 1'b1;
        data_d = rd_data;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  assign dbg_valid = state_q == SEND;
  assign dbg_busy  = state_q != IDLE;
  assign dbg_done  = state_q == DONE;
  assign dbg_addr  = idx_q;
  assign dbg_data  = data_q;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with write bypass, optional zero register
// and a non-blocking debug dump port.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     dbg_start,
  input  logic                     dbg_ready,
  output logic                     dbg_valid,
  output logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     dbg_busy,
  output logic                     dbg_done
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  always_comb begin
    mem_d = mem_q;
    if (wr_en && !(ZERO_REG != 0 && wr_addr == '0)) mem_d[wr_addr] = wr_data;
  end
  // Ports 0..NUM_RD-1 serve the datapath; the extra last port serves the dump sequencer.
  for (genvar k = 0; k <= NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    assign v = (ZERO_REG != 0 && a == '0) ? '0 : (wr_en && wr_addr == a) ? wr_data : mem_q[a];
    if (k < NUM_RD) begin : g_port
      assign a = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W] = v;
    end else begin : g_dump
      assign a = dump_addr;
      assign dump_data = v;
    end
  end
  regfile_dbg_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dump (
    .CLK      (CLK),
    .RESET    (RESET),
    .dbg_start(dbg_start),
    .dbg_ready(dbg_ready),
    .dbg_valid(dbg_valid),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .dbg_busy (dbg_busy),
    .dbg_done (dbg_done),
    .rd_addr  (dump_addr),
    .rd_data  (dump_data)
  );
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed + randomized checks of regfile_param against an array model.
module tb_regfile_param;
  logic        CLK, RESET, wr_en, dbg_start, dbg_ready;
  logic [19:0] rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [127:0] rd_data, rd0_data;
  logic        dbg_valid, dbg_busy, dbg_done;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        z_valid, z_busy, z_done;
  logic [4:0]  z_addr;
  logic [31:0] z_data;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  int dstate, dbeat, beats, dones, hit7;
  logic [31:0] ddata;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)) u_dut (
    .CLK(CLK), .RESET(RESET), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_start(dbg_start), .dbg_ready(dbg_ready), .dbg_valid(dbg_valid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_busy(dbg_busy), .dbg_done(dbg_done));

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .rd_addr(rd_addr), .rd_data(rd0_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_start(1'b0), .dbg_ready(1'b0), .dbg_valid(z_valid),
    .dbg_addr(z_addr), .dbg_data(z_data), .dbg_busy(z_busy), .dbg_done(z_done));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input bit zr, input int a);
    if (zr && a == 0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return zr ? m1[a] : m0[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m0[i] = 0;
      m1[i] = 0;
    end
    dstate = 0;
    dbeat  = 0;
    ddata  = 0;
  endtask

  // Checks all outputs against the model, then advances one clock and updates the model.
  task automatic cyc();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd%0d_a%0d", k, rd_addr[k*5 +: 5]), rd_data[k*32 +: 32], ref_rd(1, int'(rd_addr[k*5 +: 5])));
      chk($sformatf("z0_rd%0d_a%0d", k, rd_addr[k*5 +: 5]), rd0_data[k*32 +: 32], ref_rd(0, int'(rd_addr[k*5 +: 5])));
    end
    chk("dbg_valid", dbg_valid, dstate == 1);
    chk("dbg_busy", dbg_busy, dstate != 0);
    chk("dbg_done", dbg_done, dstate == 2);
    if (dstate == 1) begin
      chk($sformatf("dbg_addr_b%0d", dbeat), dbg_addr, dbeat);
      chk($sformatf("dbg_data_b%0d", dbeat), dbg_data, ddata);
    end
    @(posedge CLK);
    case (dstate)
      0: if (dbg_start) begin
        dstate = 1;
        dbeat  = 0;
        ddata  = ref_rd(1, 0);
      end
      1: if (dbg_ready) begin
        beats++;
        if (dbeat == 31) dstate = 2;
        else begin
          dbeat++;
          ddata = ref_rd(1, dbeat);
        end
      end
      default: begin
        dstate = 0;
        dones++;
      end
    endcase
    if (wr_en) begin
      m0[wr_addr] = wr_data;
      if (wr_addr != 0) m1[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, dbg_valid, 0);
    chk({tag, "_busy"}, dbg_busy, 0);
    chk({tag, "_done"}, dbg_done, 0);
    chk({tag, "_addr"}, dbg_addr, 0);
    chk({tag, "_data"}, dbg_data, 0);
  endtask

  initial begin
    CLK = 0; RESET = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    dbg_start = 0; dbg_ready = 0;
    rd_addr = {5'd9, 5'd3, 5'd31, 5'd1};
    beats = 0; dones = 0; hit7 = 0;
    #2 RESET = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_rd%0d", k), rd_data[k*32 +: 32], 0);
      chk($sformatf("rst_z0_rd%0d", k), rd0_data[k*32 +: 32], 0);
    end
    reset_checks("rst");
    model_reset();
    @(posedge CLK);
    #1 RESET = 0;

    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr[4:0] = 5;
    #1 chk("bypass_r5", rd_data[31:0], 32'hDEADBEEF);
    cyc();
    wr_en = 0;
    #1 chk("persist_r5", rd_data[31:0], 32'hDEADBEEF);
    cyc();

    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; rd_addr[4:0] = 0;
    cyc();
    wr_en = 0;
    #1;
    chk("zr1_r0", rd_data[31:0], 0);
    chk("zr0_r0", rd0_data[31:0], 32'h12345678);
    cyc();

    for (int i = 1; i <= 4; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = i;
      cyc();
    end
    wr_en = 0; rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("multiport%0d", k), rd_data[k*32 +: 32], k + 1);
    cyc();

    repeat (200) begin
      wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = $urandom;
      for (int k = 0; k < 4; k++) rd_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      cyc();
    end

    for (int i = 0; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = i * 3;
      cyc();
    end
    wr_en = 0; dbg_start = 1;
    cyc();
    dbg_start = 0; beats = 0; dones = 0;
    for (int t = 0; t < 2000 && dones == 0; t++) begin
      if (dstate == 1 && dbeat == 7 && hit7 == 0) begin
        dbg_ready = 0; wr_en = 1; wr_addr = 7; wr_data = 32'hAA; hit7 = 1;
        cyc();
        wr_en = 0;
        #1;
        chk("r7_stall_data", dbg_data, 32'd21);
        chk("r7_stall_addr", dbg_addr, 7);
      end else begin
        dbg_ready = 1'($urandom);
        dbg_start = dstate == 1 ? 1'($urandom) : 1'b0;
        cyc();
      end
    end
    dbg_start = 0;
    chk("dump_beats", beats, 32);
    chk("dump_dones", dones, 1);
    chk("dump_hit7", hit7, 1);

    dbg_ready = 1; dbg_start = 1;
    cyc();
    dbg_start = 0;
    for (int t = 0; t < 100 && !(dstate == 1 && dbeat == 10); t++) cyc();
    chk("reached_beat10", dbg_addr, 10);
    #1 RESET = 1;
    #1 reset_checks("midrst");
    model_reset();
    @(posedge CLK);
    #1 RESET = 0;
    repeat (3) cyc();
    dbg_start = 1;
    cyc();
    dbg_start = 0;
    #1;
    chk("restart_valid", dbg_valid, 1);
    chk("restart_addr", dbg_addr, 0);
    beats = 0; dones = 0;
    for (int t = 0; t < 100 && dones == 0; t++) begin
      wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = $urandom;
      cyc();
    end
    wr_en = 0;
    chk("restart_beats", beats, 32);
    chk("restart_dones", dones, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
